// File: rtl/i2c_regfile_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_regfile_ctrl
//   Register-pointer controller and RAM-port arbiter between an I2C slave
//   byte interface and a local host port. Owns a 2**AW x 8 register file
//   with one access per cycle. Keeps a prefetch copy of reg[ptr] on
//   i2c_rdata so the slave can sample transmit data at any i2c_rs strobe.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   i2c_act         slave transaction active; qualifies the three strobes
//   i2c_as          strobe: i2c_wdata is the new register pointer
//   i2c_ws          strobe: i2c_wdata is written to reg[ptr], ptr increments
//   i2c_rs          strobe: slave latches i2c_rdata, ptr increments
//   i2c_wdata       received byte from the slave
//   i2c_rdata       prefetch byte presented to the slave
//   h_req/h_we      host request (held until h_ack) and write/read select
//   h_addr/h_wdata  host register address and write data
//   h_rdata/h_ack   host read data and 1-cycle completion pulse
//   ptr_out         current register pointer
//   pf_valid        i2c_rdata currently equals reg[ptr]
//   rd_underrun     sticky flag: i2c_rs arrived while pf_valid was low
//   underrun_clr    clears rd_underrun (a new underrun wins)
// ----------------------------------------------------------------------------
module i2c_regfile_ctrl #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i2c_act,
   input  logic          i2c_as,
   input  logic          i2c_ws,
   input  logic          i2c_rs,
   input  logic [7:0]    i2c_wdata,
   output logic [7:0]    i2c_rdata,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [7:0]    h_wdata,
   output logic [7:0]    h_rdata,
   output logic          h_ack,
   output logic [AW-1:0] ptr_out,
   output logic          pf_valid,
   output logic          rd_underrun,
   input  logic          underrun_clr
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PF_WAIT,   // prefetch read issued last cycle
      ST_H_WAIT     // host access granted last cycle; h_ack is high
   } arb_state_t;

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;

   logic [7:0]    r_mem [0:(1<<AW)-1];
   logic [AW-1:0] r_ptr;
   logic          r_pf_pend;
   logic [7:0]    r_pf_data;
   logic [7:0]    r_h_rdata;
   logic          r_h_ack;
   logic          r_underrun;

   logic          w_as;
   logic          w_ws;
   logic          w_rs;
   logic [AW-1:0] w_ptr_nxt;
   logic          w_pf_issue;
   logic          w_h_grant;
   logic          w_h_match;
   logic          w_pf_valid;
   logic          w_ram_we;
   logic [AW-1:0] w_ram_addr;
   logic [7:0]    w_ram_wdata;
   logic [7:0]    w_ram_rd;

   // Strobes only count while the slave is addressed.
   assign w_as = i2c_act & i2c_as;
   assign w_ws = i2c_act & i2c_ws;
   assign w_rs = i2c_act & i2c_rs;

   always_comb begin
      w_ptr_nxt = r_ptr;
      if (w_as)
         w_ptr_nxt = i2c_wdata[AW-1:0];
      else if (w_ws || w_rs)
         w_ptr_nxt = r_ptr + AW'(1);   // wraps modulo 2**AW
   end

   // NOTE: every signal driven here gets a default first, so no path
   // through the block can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_pf_issue  = 1'b0;
      w_h_grant   = 1'b0;
      w_ram_we    = 1'b0;
      w_ram_addr  = r_ptr;
      w_ram_wdata = i2c_wdata;
      if (w_ws) begin
         // Slave write cannot be stalled; it owns the port this cycle.
         w_ram_we = 1'b1;
      end else if (r_pf_pend && !w_as && !w_rs) begin
         // A pointer change this cycle would make the read stale, so the
         // prefetch waits one cycle for the new pointer to land.
         w_pf_issue  = 1'b1;
         w_state_nxt = ST_PF_WAIT;
      end else if (h_req && (r_state != ST_H_WAIT)) begin
         // During H_WAIT h_req is still high from the op being acked.
         w_h_grant   = 1'b1;
         w_state_nxt = ST_H_WAIT;
         w_ram_addr  = h_addr;
         w_ram_we    = h_we;
         w_ram_wdata = h_wdata;
      end
   end

   // Host writes to the byte the slave will read next must refresh it;
   // compared against the post-strobe pointer.
   assign w_h_match  = w_h_grant && h_we && (h_addr == w_ptr_nxt);
   assign w_pf_valid = !r_pf_pend && (r_state != ST_PF_WAIT);
   assign w_ram_rd   = r_mem[w_ram_addr];

   // NOTE: the register-file array has no reset; clearing it would force
   // flops instead of RAM and the contents are undefined until written.
   always_ff @(posedge clk) begin
      if (w_ram_we)
         r_mem[w_ram_addr] <= w_ram_wdata;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_pf_pend  <= 1'b1;   // refresh reg[0] after reset
         r_pf_data  <= '0;
         r_h_rdata  <= '0;
         r_h_ack    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_ptr   <= w_ptr_nxt;
         r_h_ack <= w_h_grant;
         // Setting wins: a refresh requested while one is issuing must
         // trigger another read after the stale one completes.
         if (w_as || w_ws || w_rs || w_h_match)
            r_pf_pend <= 1'b1;
         else if (w_pf_issue)
            r_pf_pend <= 1'b0;
         if (w_pf_issue)
            r_pf_data <= w_ram_rd;
         if (w_h_grant && !h_we)
            r_h_rdata <= w_ram_rd;
         if (w_rs && !w_pf_valid)
            r_underrun <= 1'b1;
         else if (underrun_clr)
            r_underrun <= 1'b0;
      end
   end

   assign i2c_rdata   = r_pf_data;
   assign h_rdata     = r_h_rdata;
   assign h_ack       = r_h_ack;
   assign ptr_out     = r_ptr;
   assign pf_valid    = w_pf_valid;
   assign rd_underrun = r_underrun;

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2c_regfile_ctrl
//   Directed bench for i2c_regfile_ctrl. Stimulus tasks push expected host
//   read data and expected slave-read bytes into queues; a monitor on the
//   falling clock edge pops and compares whenever h_ack or i2c_rs occurs.
//   A reference copy of the register file and pointer supplies expectations.
// ----------------------------------------------------------------------------
module tb_i2c_regfile_ctrl;

   localparam int AW = 4;

   typedef struct {
      logic       we;
      logic [7:0] data;
   } h_exp_t;

   typedef struct {
      logic       valid;
      logic       chk;
      logic [7:0] data;
   } rs_exp_t;

   logic          clk;
   logic          rst;
   logic          i2c_act;
   logic          i2c_as;
   logic          i2c_ws;
   logic          i2c_rs;
   logic [7:0]    i2c_wdata;
   logic [7:0]    i2c_rdata;
   logic          h_req;
   logic          h_we;
   logic [AW-1:0] h_addr;
   logic [7:0]    h_wdata;
   logic [7:0]    h_rdata;
   logic          h_ack;
   logic [AW-1:0] ptr_out;
   logic          pf_valid;
   logic          rd_underrun;
   logic          underrun_clr;

   int            n_tests;
   int            n_fail;
   h_exp_t        h_q[$];
   rs_exp_t       rs_q[$];
   logic [7:0]    model [0:(1<<AW)-1];
   logic [AW-1:0] mptr;

   i2c_regfile_ctrl #(.AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .i2c_act      (i2c_act),
      .i2c_as       (i2c_as),
      .i2c_ws       (i2c_ws),
      .i2c_rs       (i2c_rs),
      .i2c_wdata    (i2c_wdata),
      .i2c_rdata    (i2c_rdata),
      .h_req        (h_req),
      .h_we         (h_we),
      .h_addr       (h_addr),
      .h_wdata      (h_wdata),
      .h_rdata      (h_rdata),
      .h_ack        (h_ack),
      .ptr_out      (ptr_out),
      .pf_valid     (pf_valid),
      .rd_underrun  (rd_underrun),
      .underrun_clr (underrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next n rising edges.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_as(input logic [7:0] d);
      i2c_as = 1'b1; i2c_wdata = d;
      if (i2c_act) mptr = d[AW-1:0];
      idle(1);
      i2c_as = 1'b0;
   endtask

   task automatic do_ws(input logic [7:0] d);
      i2c_ws = 1'b1; i2c_wdata = d;
      if (i2c_act) begin
         model[mptr] = d;
         mptr = mptr + 1'b1;
      end
      idle(1);
      i2c_ws = 1'b0;
   endtask

   // exp_valid: whether pf_valid must be high at the strobe. When it is not,
   // d is the stale byte expected on i2c_rdata (checked only if chk).
   task automatic do_rs(input logic exp_valid, input logic chk, input logic [7:0] d);
      rs_exp_t e;
      e.valid = exp_valid;
      e.chk   = chk;
      e.data  = exp_valid ? model[mptr] : d;
      i2c_rs  = 1'b1;
      if (i2c_act) begin
         rs_q.push_back(e);
         mptr = mptr + 1'b1;
      end
      idle(1);
      i2c_rs = 1'b0;
   endtask

   // Returns in the h_ack cycle with h_req already dropped.
   task automatic host_op(input logic we, input logic [AW-1:0] addr,
                          input logic [7:0] wd, input int max_lat);
      h_exp_t e;
      int     lat;
      e.we   = we;
      e.data = we ? 8'h00 : model[addr];
      if (we) model[addr] = wd;
      h_q.push_back(e);
      h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wd;
      lat = 0;
      do begin
         idle(1);
         lat++;
      end while (!h_ack && lat < 12);
      h_req = 1'b0;
      check($sformatf("host ack latency %0d <= %0d", lat, max_lat), 32'(lat <= max_lat), 1);
   endtask

   task automatic wait_pf(input int max_cyc);
      int n;
      n = 0;
      while (!pf_valid && n < max_cyc) begin
         idle(1);
         n++;
      end
      check("pf_valid after refresh", pf_valid, 1'b1);
   endtask

   // Scoreboard monitor, sampling on the inactive edge.
   always @(negedge clk) begin : mon
      h_exp_t  he;
      rs_exp_t re;
      if (!rst) begin
         if (h_ack) begin
            if (h_q.size() == 0) begin
               check("unexpected h_ack", 1'b1, 1'b0);
            end else begin
               he = h_q.pop_front();
               if (!he.we) check("host rdata", h_rdata, he.data);
            end
         end
         if (i2c_act && i2c_rs) begin
            if (rs_q.size() == 0) begin
               check("unexpected rs", 1'b1, 1'b0);
            end else begin
               re = rs_q.pop_front();
               check("pf_valid at rs", pf_valid, re.valid);
               if (re.chk) check("i2c_rdata at rs", i2c_rdata, re.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; mptr = '0;
      rst = 1'b1; i2c_act = 1'b1; i2c_as = 1'b0; i2c_ws = 1'b0; i2c_rs = 1'b0;
      i2c_wdata = '0; h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      underrun_clr = 1'b0;
      for (int i = 0; i < (1 << AW); i++) model[i] = 8'h00;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst ptr_out", ptr_out, 0);
      check("rst i2c_rdata", i2c_rdata, 8'h00);
      check("rst h_rdata", h_rdata, 8'h00);
      check("rst h_ack", h_ack, 1'b0);
      check("rst rd_underrun", rd_underrun, 1'b0);
      check("rst pf_valid (refresh pending)", pf_valid, 1'b0);
      rst = 1'b0;
      idle(3);

      // Host write then read of reg 3, idle port -> ack 1 cycle after request
      host_op(1'b1, 4'd3, 8'hA5, 1);
      idle(1);
      host_op(1'b0, 4'd3, 8'h00, 1);
      idle(1);

      // Fill the register file with known contents
      for (int i = 0; i < (1 << AW); i++) begin
         host_op(1'b1, AW'(i), 8'h30 + 8'(i), 2);
         idle(1);
      end
      idle(3);

      // I2C pointer write then two data writes
      do_as(8'h03);
      do_ws(8'h11);
      do_ws(8'h22);
      check("ptr after as/ws/ws", ptr_out, 5);
      check("pf_valid low right after ws", pf_valid, 1'b0);
      wait_pf(3);
      check("i2c_rdata = reg5", i2c_rdata, 8'h35);
      host_op(1'b0, 4'd3, 8'h00, 2);
      idle(1);
      host_op(1'b0, 4'd4, 8'h00, 2);
      idle(1);

      // Pointer wrap at the top of the register file
      do_as(8'h0F);
      do_ws(8'h77);
      check("ptr wraps to 0", ptr_out, 0);
      idle(2);
      do_rs(1'b1, 1'b1, 8'h00);
      check("ptr after first rs", ptr_out, 1);
      idle(2);
      check("i2c_rdata = reg1", i2c_rdata, 8'h31);
      do_rs(1'b1, 1'b1, 8'h00);
      check("ptr after second rs", ptr_out, 2);
      host_op(1'b0, 4'd15, 8'h00, 2);
      idle(3);

      // Host write to reg[ptr] while idle -> two-cycle refresh window
      host_op(1'b1, 4'd2, 8'hC3, 1);
      check("pf_valid low 1st cycle", pf_valid, 1'b0);
      idle(1);
      check("pf_valid low 2nd cycle", pf_valid, 1'b0);
      idle(1);
      check("pf_valid back high", pf_valid, 1'b1);
      check("i2c_rdata shows host write", i2c_rdata, 8'hC3);
      check("no underrun from host write", rd_underrun, 1'b0);
      idle(1);

      // Host request held during back-to-back ws then rs
      do_as(8'h06);
      idle(3);
      fork
         host_op(1'b1, 4'd9, 8'h5C, 4);
         begin
            do_ws(8'hE1);
            do_rs(1'b0, 1'b1, 8'h36);   // stale prefetch of reg6
         end
      join
      idle(1);
      check("underrun after ws->rs", rd_underrun, 1'b1);
      underrun_clr = 1'b1;
      check("underrun held during clr cycle", rd_underrun, 1'b1);
      idle(1);
      underrun_clr = 1'b0;
      check("underrun cleared next cycle", rd_underrun, 1'b0);
      idle(3);
      host_op(1'b0, 4'd6, 8'h00, 2);
      idle(1);
      host_op(1'b0, 4'd9, 8'h00, 2);
      idle(2);
      do_rs(1'b1, 1'b1, 8'h00);
      idle(3);

      // rs one cycle after as -> sticky underrun; set beats clear
      do_as(8'h02);
      do_rs(1'b0, 1'b0, 8'h00);
      check("underrun set by early rs", rd_underrun, 1'b1);
      idle(2);
      check("underrun sticky", rd_underrun, 1'b1);
      do_as(8'h05);
      underrun_clr = 1'b1;
      do_rs(1'b0, 1'b0, 8'h00);
      underrun_clr = 1'b0;
      check("set has priority over clr", rd_underrun, 1'b1);
      underrun_clr = 1'b1;
      idle(1);
      underrun_clr = 1'b0;
      check("underrun cleared", rd_underrun, 1'b0);
      idle(3);

      // Strobes ignored while the slave is not addressed; ptr retained
      i2c_act = 1'b0;
      do_ws(8'hFF);
      do_as(8'h0A);
      do_rs(1'b1, 1'b1, 8'h00);
      check("ptr retained with act low", ptr_out, 6);
      i2c_act = 1'b1;
      idle(2);
      check("pf_valid retained", pf_valid, 1'b1);
      host_op(1'b0, 4'd6, 8'h00, 2);
      idle(2);
      do_rs(1'b1, 1'b1, 8'h00);
      idle(3);

      // Reset during a host request: no h_ack, pointer and refresh reset
      h_req = 1'b1; h_we = 1'b0; h_addr = 4'd1;
      #3 rst = 1'b1;
      @(negedge clk);
      check("no h_ack across reset", h_ack, 1'b0);
      check("ptr reset mid-op", ptr_out, 0);
      check("refresh pending after reset", pf_valid, 1'b0);
      idle(1);
      h_req = 1'b0;
      check("still no h_ack", h_ack, 1'b0);
      rst = 1'b0;
      mptr = '0;
      idle(3);
      host_op(1'b0, 4'd1, 8'h00, 2);
      idle(2);
      do_rs(1'b1, 1'b1, 8'h00);
      idle(3);

      check("host scoreboard drained", h_q.size(), 0);
      check("rs scoreboard drained", rs_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
